// File: rtl/blink_led_caller_pkg.sv
// Shared types for the blink-LED method caller: FSM state encoding and error codes.
package blink_led_caller_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_READY = 2'd1,
    REQ        = 2'd2,
    RUN        = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_READY_TO = 2'd1;
  localparam logic [1:0] ERR_ACK_TO   = 2'd2;
  localparam logic [1:0] ERR_ABORT    = 2'd3;

endpackage

// File: rtl/blink_led_caller_meter.sv
// Measures high/low run lengths of the core's LED output with saturating counters.
module led_period_meter
  import blink_led_caller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             led_obs,
  output logic [CNT_W-1:0] high_cycles,
  output logic [CNT_W-1:0] low_cycles,
  output logic             period_strobe
);

  logic             led_d;
  logic             seen_fall;
  logic [CNT_W-1:0] count;
  logic             lvl_chg;
  logic             rise;
  logic             fall;

  assign lvl_chg = led_obs != led_d;
  assign rise    = led_obs & ~led_d;
  assign fall    = ~led_obs & led_d;

  // count holds the length of the level that just ended when an edge is seen
  always_ff @(posedge clk) begin
    if (reset) begin
      led_d         <= 1'b0;
      seen_fall     <= 1'b0;
      count         <= '0;
      high_cycles   <= '0;
      low_cycles    <= '0;
      period_strobe <= 1'b0;
    end else begin
      led_d         <= led_obs;
      period_strobe <= 1'b0;
      if (lvl_chg)
        count <= CNT_W'(1);
      else if (count != '1)
        count <= count + CNT_W'(1);
      if (fall) begin
        high_cycles <= count;
        seen_fall   <= 1'b1;
      end
      if (rise && seen_fall) begin
        low_cycles    <= count;
        period_strobe <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/blink_led_caller.sv
// Initiator for the blink-LED core's method-call and field-write interfaces,
// with a watchdog on each handshake phase and an LED period monitor.
module blink_led_caller
  import blink_led_caller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES     = 1024,
  parameter int RUN_TIMEOUT_CYCLES = 0,
  parameter int CNT_W              = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             run_req,
  input  logic             run_busy,
  output logic             call_busy,
  output logic             call_done,
  output logic             call_err,
  output logic [1:0]       err_code,
  input  logic             led_set,
  input  logic             led_val,
  output logic             led_in,
  output logic             led_we,
  input  logic             led_obs,
  output logic [CNT_W-1:0] high_cycles,
  output logic [CNT_W-1:0] low_cycles,
  output logic             period_strobe
);

  localparam logic [31:0] TO_LIM     = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] RUN_TO_LIM = 32'(RUN_TIMEOUT_CYCLES);

  state_t      state, state_nx;
  logic [31:0] tcnt, tcnt_nx, tcnt_inc;
  logic        run_req_nx, call_busy_nx, call_done_nx, call_err_nx;
  logic [1:0]  err_code_nx;
  logic        fail;
  logic [1:0]  fail_code;

  assign tcnt_inc = tcnt + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tcnt      <= '0;
      run_req   <= 1'b0;
      call_busy <= 1'b0;
      call_done <= 1'b0;
      call_err  <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_nx;
      tcnt      <= tcnt_nx;
      run_req   <= run_req_nx;
      call_busy <= call_busy_nx;
      call_done <= call_done_nx;
      call_err  <= call_err_nx;
      err_code  <= err_code_nx;
    end
  end

  // A timeout fires on the edge that would make the in-state count reach the limit,
  // so the FSM spends exactly that many cycles in the state.
  always_comb begin
    state_nx     = state;
    tcnt_nx      = (state == IDLE) ? 32'd0 : tcnt_inc;
    run_req_nx   = run_req;
    call_busy_nx = call_busy;
    call_done_nx = 1'b0;
    call_err_nx  = 1'b0;
    err_code_nx  = err_code;
    fail         = 1'b0;
    fail_code    = ERR_NONE;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx     = WAIT_READY;
          call_busy_nx = 1'b1;
          err_code_nx  = ERR_NONE;
          tcnt_nx      = '0;
        end
      end
      WAIT_READY: begin
        if (!run_busy) begin
          state_nx   = REQ;
          run_req_nx = 1'b1;
          tcnt_nx    = '0;
        end else if (tcnt_inc == TO_LIM) begin
          fail      = 1'b1;
          fail_code = ERR_READY_TO;
        end
      end
      REQ: begin
        if (run_busy) begin
          state_nx   = RUN;
          run_req_nx = 1'b0;
          tcnt_nx    = '0;
        end else if (tcnt_inc == TO_LIM) begin
          fail      = 1'b1;
          fail_code = ERR_ACK_TO;
        end
      end
      RUN: begin
        if (!run_busy) begin
          state_nx     = IDLE;
          call_busy_nx = 1'b0;
          call_done_nx = 1'b1;
          tcnt_nx      = '0;
        end else if (RUN_TO_LIM != 32'd0 && tcnt_inc == RUN_TO_LIM) begin
          fail      = 1'b1;
          fail_code = ERR_ACK_TO;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Abort overrides completion and timeout decided above.
    if (abort && state != IDLE) begin
      fail      = 1'b1;
      fail_code = ERR_ABORT;
    end

    if (fail) begin
      state_nx     = IDLE;
      tcnt_nx      = '0;
      run_req_nx   = 1'b0;
      call_busy_nx = 1'b0;
      call_done_nx = 1'b0;
      call_err_nx  = 1'b1;
      err_code_nx  = fail_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_we <= 1'b0;
      led_in <= 1'b0;
    end else begin
      led_we <= led_set;
      if (led_set)
        led_in <= led_val;
    end
  end

  led_period_meter #(.CNT_W(CNT_W)) u_meter (
    .clk           (clk),
    .reset         (reset),
    .led_obs       (led_obs),
    .high_cycles   (high_cycles),
    .low_cycles    (low_cycles),
    .period_strobe (period_strobe)
  );

endmodule

// File: tb/tb_blink_led_caller.sv
// Bench for blink_led_caller: table-driven field writes, hand sequences for the
// call FSM, and a scoreboard of expected LED durations.
module tb_blink_led_caller;

  localparam int TB_TO    = 16;
  localparam int TB_CNT_W = 4;
  localparam int SAT_MAX  = (1 << TB_CNT_W) - 1;

  logic                clk;
  logic                reset;
  logic                start;
  logic                abort;
  logic                run_req;
  logic                run_busy;
  logic                call_busy;
  logic                call_done;
  logic                call_err;
  logic [1:0]          err_code;
  logic                led_set;
  logic                led_val;
  logic                led_in;
  logic                led_we;
  logic                led_obs;
  logic [TB_CNT_W-1:0] high_cycles;
  logic [TB_CNT_W-1:0] low_cycles;
  logic                period_strobe;

  blink_led_caller #(
    .TIMEOUT_CYCLES     (TB_TO),
    .RUN_TIMEOUT_CYCLES (0),
    .CNT_W              (TB_CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .run_req       (run_req),
    .run_busy      (run_busy),
    .call_busy     (call_busy),
    .call_done     (call_done),
    .call_err      (call_err),
    .err_code      (err_code),
    .led_set       (led_set),
    .led_val       (led_val),
    .led_in        (led_in),
    .led_we        (led_we),
    .led_obs       (led_obs),
    .high_cycles   (high_cycles),
    .low_cycles    (low_cycles),
    .period_strobe (period_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic set;
    logic val;
    logic exp_we;
    logic exp_in;
  } fw_vec_t;

  typedef struct {
    logic we;
    logic din;
  } fw_exp_t;

  typedef struct {
    bit is_low;
    int val;
  } led_exp_t;

  fw_vec_t  fw_tab[6];
  fw_exp_t  fw_q[$];
  led_exp_t led_q[$];

  bit m_seen_fall = 0;
  int m_run_len   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int satv(input int n);
    return (n > SAT_MAX) ? SAT_MAX : n;
  endfunction

  // Drive one LED level for n cycles; expected durations come from the bench's run lengths.
  task automatic led_run(input logic lvl, input int n);
    led_exp_t e;
    bit       pushed;
    bit       first_rise;
    for (int i = 0; i < n; i++) begin
      pushed     = 0;
      first_rise = 0;
      if (i == 0 && lvl != led_obs) begin
        if (!lvl) begin
          led_q.push_back('{0, satv(m_run_len)});
          m_seen_fall = 1;
          pushed      = 1;
        end else if (m_seen_fall) begin
          led_q.push_back('{1, satv(m_run_len)});
          pushed = 1;
        end else begin
          first_rise = 1;
        end
      end
      led_obs = lvl;
      step();
      if (pushed) begin
        e = led_q.pop_front();
        if (e.is_low) begin
          chk("low_cycles", 32'(low_cycles), 32'(e.val));
          chk("period_strobe_hi", 32'(period_strobe), 32'd1);
        end else begin
          chk("high_cycles", 32'(high_cycles), 32'(e.val));
        end
      end else if (first_rise) begin
        chk("first_low_no_strobe", 32'(period_strobe), 32'd0);
      end else if (i == 1 && lvl && m_seen_fall) begin
        chk("strobe_one_cycle", 32'(period_strobe), 32'd0);
      end
    end
    m_run_len = n;
  endtask

  initial begin
    int       n;
    bit       saw_req;
    fw_exp_t  fe;

    fw_tab[0] = '{1'b1, 1'b1, 1'b1, 1'b1};
    fw_tab[1] = '{1'b0, 1'b0, 1'b0, 1'b1};
    fw_tab[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    fw_tab[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    fw_tab[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    fw_tab[5] = '{1'b0, 1'b0, 1'b0, 1'b1};

    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    run_busy = 1'b1;
    led_set  = 1'b0;
    led_val  = 1'b0;
    led_obs  = 1'b0;
    repeat (3) step();
    chk("rst_run_req", 32'(run_req), 32'd0);
    chk("rst_call_busy", 32'(call_busy), 32'd0);
    chk("rst_done_err", 32'({call_done, call_err}), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_led_we_in", 32'({led_we, led_in}), 32'd0);
    chk("rst_durations", 32'({high_cycles, low_cycles, period_strobe}), 32'd0);
    reset = 1'b0;

    // Field writes: expected pushed at drive time, popped one edge later.
    for (int i = 0; i < 6; i++) begin
      led_set = fw_tab[i].set;
      led_val = fw_tab[i].val;
      fw_q.push_back('{fw_tab[i].exp_we, fw_tab[i].exp_in});
      step();
      fe = fw_q.pop_front();
      chk($sformatf("led_we[%0d]", i), 32'(led_we), 32'(fe.we));
      chk($sformatf("led_in[%0d]", i), 32'(led_in), 32'(fe.din));
    end
    led_set = 1'b0;

    // Normal call: core busy at power-up, then ready, ack two cycles late, run 10 cycles.
    repeat (5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("cc_wait_busy", 32'(call_busy), 32'd1);
    chk("cc_wait_noreq", 32'(run_req), 32'd0);
    run_busy = 1'b0;
    step();
    chk("cc_req", 32'(run_req), 32'd1);
    step();
    chk("cc_req_held", 32'(run_req), 32'd1);
    run_busy = 1'b1;
    step();
    chk("cc_run_req_drop", 32'(run_req), 32'd0);
    chk("cc_run_busy", 32'(call_busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      step();
      if (i == 3) chk("cc_start_ignored", 32'({call_busy, run_req}), 32'b10);
    end
    start    = 1'b0;
    run_busy = 1'b0;
    step();
    chk("cc_done", 32'(call_done), 32'd1);
    chk("cc_not_busy", 32'(call_busy), 32'd0);
    chk("cc_err_code", 32'({call_err, err_code}), 32'd0);
    step();
    chk("cc_done_pulse", 32'({call_done, call_busy}), 32'd0);

    // Ready timeout: busy stuck high.
    run_busy = 1'b1;
    start    = 1'b1;
    step();
    start   = 1'b0;
    n       = 0;
    saw_req = 0;
    while (call_busy === 1'b1 && n < 100) begin
      if (run_req) saw_req = 1;
      n++;
      step();
    end
    chk("rto_cycles", 32'(n), 32'(TB_TO));
    chk("rto_err", 32'(call_err), 32'd1);
    chk("rto_code", 32'(err_code), 32'd1);
    chk("rto_never_req", 32'(saw_req), 32'd0);
    step();
    chk("rto_code_held", 32'({call_err, err_code}), 32'd1);

    // Ack timeout: ready immediately, busy never rises.
    run_busy = 1'b0;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("ato_code_cleared", 32'(err_code), 32'd0);
    step();
    n = 0;
    while (run_req === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("ato_cycles", 32'(n), 32'(TB_TO));
    chk("ato_err", 32'({call_err, err_code}), 32'b110);
    chk("ato_idle", 32'({call_busy, run_req}), 32'd0);

    // Abort in RUN, coinciding with completion; abort must win.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    run_busy = 1'b1;
    step();
    step();
    abort    = 1'b1;
    run_busy = 1'b0;
    step();
    abort = 1'b0;
    chk("abt_err", 32'({call_err, err_code}), 32'b111);
    chk("abt_no_done", 32'({call_done, call_busy, run_req}), 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abt_idle_noeffect", 32'({call_err, call_done, err_code}), 32'b0011);

    // Reset mid-call.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rmc_req", 32'(run_req), 32'd1);
    reset = 1'b1;
    step();
    chk("rmc_drop", 32'({run_req, call_busy, call_done, call_err}), 32'd0);
    reset = 1'b0;
    step();
    chk("rmc_quiet", 32'({call_done, call_err, err_code}), 32'd0);

    // LED period: meter was just reset, so the first low interval is unreported.
    led_obs     = 1'b0;
    m_seen_fall = 0;
    led_run(1'b0, 4);
    for (int p = 0; p < 3; p++) begin
      led_run(1'b1, 7);
      led_run(1'b0, 3);
    end
    led_run(1'b1, 40);
    led_run(1'b0, 2);
    led_run(1'b1, 2);
    chk("led_q_empty", 32'(led_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_led_caller.md
Name: blink_led_caller

Overview:
- Initiator side of the generated-method invocation interface (`run_req`/`run_busy`) and field-write interface (`led_in`/`led_we`) exposed by the blink-LED core.
- Issues a method call on a host `start` pulse, tracks completion, reports timeout and abort.
- Independently measures the high and low durations of the core's `led_out` so software and benches can check the blink period.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles allowed in WAIT_READY or REQ before error.
- RUN_TIMEOUT_CYCLES, 0: max cycles in RUN; 0 disables, because methods may loop forever.
- CNT_W, 32: width of LED duration counters and outputs.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: request one method invocation
- abort  in  1  pulse: cancel the invocation in progress
- run_req  out  1  method request to core
- run_busy  in  1  core busy/ready status
- call_busy  out  1  caller not IDLE
- call_done  out  1  one-cycle pulse: method completed
- call_err  out  1  one-cycle pulse: timeout or abort
- err_code  out  2  0 none, 1 ready-timeout, 2 ack/run-timeout, 3 abort; held until the next start
- led_set  in  1  pulse: write LED field
- led_val  in  1  value for field write
- led_in  out  1  field write data to core
- led_we  out  1  field write enable to core
- led_obs  in  1  core's `led_out`
- high_cycles  out  CNT_W  last measured high duration
- low_cycles  out  CNT_W  last measured low duration
- period_strobe  out  1  pulse when `low_cycles` updates and a full period is known

Behaviour:
- Interface: reset `reset`, synchronous, active-high; clock `clk`. All outputs are registered.
- Reset values: `run_req`=0, `call_busy`=0, `call_done`=0, `call_err`=0, `err_code`=0, `led_in`=0, `led_we`=0, `high_cycles`=0, `low_cycles`=0, `period_strobe`=0. FSM enters IDLE; internal `led_d`=0, count=0, `seen_fall`=0.
- Reset mid-call drops `run_req` on the next edge; no `call_done` or `call_err` is issued.
- FSM states: IDLE, WAIT_READY, REQ, RUN.
- IDLE:
  - `start`=1 -> WAIT_READY, `call_busy`=1, `err_code`<=0.
  - `start` while not IDLE is ignored.
- WAIT_READY:
  - `run_busy`=0 -> REQ, `run_req`<=1.
  - The core powers up busy=1, so this wait is normal.
- REQ:
  - `run_req` held at 1 until `run_busy`=1 is sampled.
  - Then -> RUN, `run_req`<=0 on the same edge.
- RUN:
  - `run_busy`=0 -> IDLE; `call_done`=1 for one cycle; `call_busy`<=0.
- Timeout counter:
  - Cleared on every state entry; increments each cycle in WAIT_READY/REQ/RUN.
  - Reaching TIMEOUT_CYCLES in WAIT_READY -> IDLE, `err_code`=1.
  - Reaching TIMEOUT_CYCLES in REQ -> IDLE, `err_code`=2.
  - In RUN with RUN_TIMEOUT_CYCLES≠0, reaching that limit -> IDLE, `err_code`=2.
  - On every timeout: `call_err` pulses and `run_req`<=0.
- `abort` in a non-IDLE state:
  - -> IDLE next edge, `run_req`<=0, `err_code`=3, `call_err` pulse.
  - Abort has priority over timeout and completion in the same cycle.
  - Abort in IDLE: no effect.
- Field write:
  - `led_set`=1 -> next cycle `led_we`=1 (one cycle), `led_in`=`led_val`.
  - `led_in` holds its value afterwards.
  - Independent of the FSM state.
  - Back-to-back `led_set` gives back-to-back `led_we` pulses.
- LED monitor:
  - `led_d`<=`led_obs` every cycle; edge when `led_obs`≠`led_d`.
  - On an edge, count<=1; otherwise count<=count+1, saturating at 2^CNT_W−1.
  - A level present for N cycles on `led_obs` reports exactly N.
  - Falling edge (`led_obs`=0, `led_d`=1): `high_cycles`<=count; `seen_fall`<=1.
  - Rising edge: `low_cycles`<=count, written only if `seen_fall`=1. The first low interval after reset is not reported.
  - `period_strobe`=1 in the same cycle `low_cycles` updates.
  - Saturated values stay at max until the next edge.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=0, WAIT_READY=1, REQ=2, RUN=3.
  - `err_code` constants: ERR_NONE, ERR_READY_TO, ERR_ACK_TO, ERR_ABORT.
- One sub-module: `led_period_meter` (edge detect, saturating counter, `high_cycles`/`low_cycles`/`period_strobe`), parameterised by CNT_W.

Test Plan:
- Call completes: `run_busy`=1 for 5 cycles, `start`, then `run_busy`=0 -> REQ with `run_req`=1. Model raises busy 2 cycles later -> `run_req` falls the same edge RUN is entered. Busy drops after 10 cycles -> `call_done` one pulse, `err_code`=0.
- Ready timeout: TIMEOUT_CYCLES=16, `run_busy` stuck 1, `start` -> `call_err` after 16 cycles in WAIT_READY, `err_code`=1, `run_req` never asserted.
- Ack timeout, then abort:
  - Busy never rises in REQ -> `err_code`=2 after 16 cycles, `run_req`=0.
  - Separately, `abort` during RUN -> `err_code`=3, `call_done` not issued.
- Field write: `led_set`=1, `led_val`=1 -> `led_we` pulse next cycle with `led_in`=1. Two consecutive sets with `led_val`=0,1 -> two `led_we` pulses, `led_in`=0 then 1.
- LED period: drive `led_obs` high 7 / low 3 repeatedly. First falling edge -> `high_cycles`=7. Following rising edge -> `low_cycles`=3 and `period_strobe`=1. The first low interval after reset produces no strobe.
- Saturation with CNT_W=4: hold `led_obs` high 40 cycles -> `high_cycles`=15 at the falling edge.
